// File: rtl/pipe_stream_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stream_pkg
// Shared definitions for the pipe column stream generator:
//   - pipe_state_e : column-sequencer states (empty run / pipe run)
//   - LFSR_TAPS    : Galois feedback mask for x^8+x^6+x^5+x^4+1 (right shift)
//   - gap_mask     : builds a column with a hole of 'gap' rows starting at 'off'
//   - mod_u8       : single-cycle remainder of an 8-bit value by a 6-bit divisor
// -----------------------------------------------------------------------------
package pipe_stream_pkg;

  typedef enum logic [0:0] {
    S_SPACE = 1'b0,
    S_PIPE  = 1'b1
  } pipe_state_e;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int         MAX_ROWS  = 32;

  // Column of pipe pixels (1) with rows off .. off+gap-1 cleared to form the gap.
  // Always MAX_ROWS wide; callers truncate to their own display height.
  function automatic logic [MAX_ROWS-1:0] gap_mask(input logic [5:0] off,
                                                   input logic [5:0] gap);
    logic [MAX_ROWS-1:0] m;
    logic [6:0]          hi;
    hi = {1'b0, off} + {1'b0, gap};
    for (int r = 0; r < MAX_ROWS; r++) begin
      if ((7'(r) >= {1'b0, off}) && (7'(r) < hi)) begin
        m[r] = 1'b0;
      end else begin
        m[r] = 1'b1;
      end
    end
    return m;
  endfunction

  // Restoring long division, one compare-subtract per dividend bit.
  // The partial remainder stays below div (<= 32) before each shift, so 7 bits suffice.
  function automatic logic [5:0] mod_u8(input logic [7:0] val,
                                        input logic [5:0] div);
    logic [6:0] rem;
    rem = 7'd0;
    for (int i = 7; i >= 0; i--) begin
      rem = {rem[5:0], val[i]};
      if (rem >= {1'b0, div}) begin
        rem = rem - {1'b0, div};
      end else begin
        rem = rem;
      end
    end
    return rem[5:0];
  endfunction

endpackage

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// Free-running 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting right.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset, loads SEED
//   value  out  current LFSR state (registered)
// -----------------------------------------------------------------------------
module lfsr8
  import pipe_stream_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] value
);

  // Advance the LFSR on every clock edge out of reset; feedback from the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else begin
      value <= {1'b0, value[7:1]} ^ (value[0] ? LFSR_TAPS : 8'h00);
    end
  end

endmodule

// File: rtl/pipe_stream_gen.sv
// -----------------------------------------------------------------------------
// pipe_stream_gen
// Streams display columns for the scrolling obstacle field: SPACING empty
// columns, then PIPE_WIDTH identical pipe columns carrying one gap at a
// pseudo-random height. Output is a registered valid/ready slice.
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   enable         in   permits loading new beats (low = pause)
//   hard_mode      in   1: gap GAP_MIN, 0: gap GAP_MAX (sampled at pipe start)
//   col_ready      in   consumer accepts the current beat
//   col_valid      out  column holds a valid beat
//   column         out  ROWS-bit column, 1 = pipe pixel
//   pipe_start     out  current beat is the first column of a pipe
//   pipes_emitted  out  pipes started, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module pipe_stream_gen
  import pipe_stream_pkg::*;
#(
  parameter int         ROWS       = 16,
  parameter int         PIPE_WIDTH = 2,
  parameter int         SPACING    = 3,
  parameter int         GAP_MIN    = 3,
  parameter int         GAP_MAX    = 6,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            hard_mode,
  input  logic            col_ready,
  output logic            col_valid,
  output logic [ROWS-1:0] column,
  output logic            pipe_start,
  output logic [15:0]     pipes_emitted
);

  localparam int CNT_MAX = (PIPE_WIDTH > SPACING) ? PIPE_WIDTH : SPACING;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SPACE_LAST = CNT_W'(SPACING - 1);
  localparam logic [CNT_W-1:0] PIPE_LAST  = CNT_W'(PIPE_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [5:0]       GAP_MIN_V  = 6'(GAP_MIN);
  localparam logic [5:0]       GAP_MAX_V  = 6'(GAP_MAX);
  localparam logic [5:0]       ROWS_P1    = 6'(ROWS + 1);

  pipe_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ROWS-1:0]  mask_r;
  logic [7:0]       lfsr_s;
  logic             load_s;
  logic [5:0]       gap_s;
  logic [5:0]       range_s;
  logic [5:0]       off_s;
  logic [ROWS-1:0]  mask_s;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr_s)
  );

  // A new beat may be written when the slot is empty or is being drained this cycle.
  assign load_s = enable && (!col_valid || col_ready);

  // Gap placement for a pipe starting this cycle: off is uniform-ish over
  // 0 .. ROWS-gap so the whole gap always fits on the display.
  always_comb begin
    gap_s   = hard_mode ? GAP_MIN_V : GAP_MAX_V;
    range_s = ROWS_P1 - gap_s;
    off_s   = mod_u8(lfsr_s, range_s);
    mask_s  = ROWS'(gap_mask(off_s, gap_s));
  end

  // Column sequencer and output slice; the FSM only moves when a beat is loaded,
  // so a stalled or paused stream resumes exactly where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_valid     <= 1'b0;
      column        <= '0;
      pipe_start    <= 1'b0;
      pipes_emitted <= 16'd0;
      state_r       <= S_SPACE;
      cnt_r         <= CNT_ZERO;
      mask_r        <= '1;
    end else if (load_s) begin
      col_valid <= 1'b1;
      case (state_r)
        S_SPACE: begin
          column     <= '0;
          pipe_start <= 1'b0;
          if (cnt_r == SPACE_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= S_PIPE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_PIPE: begin
          if (cnt_r == CNT_ZERO) begin
            column     <= mask_s;
            mask_r     <= mask_s;
            pipe_start <= 1'b1;
            if (pipes_emitted != 16'hFFFF) begin
              pipes_emitted <= pipes_emitted + 16'd1;
            end else begin
              pipes_emitted <= pipes_emitted;
            end
          end else begin
            column     <= mask_r;
            pipe_start <= 1'b0;
          end
          if (cnt_r == PIPE_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= S_SPACE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= S_SPACE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end else if (col_valid && col_ready) begin
      col_valid <= 1'b0;
    end else begin
      col_valid <= col_valid;
    end
  end

endmodule
